// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan sequencer: fetches bit-plane rows into the planes cache, shifts them to the panel,
// latches and displays each plane for BASE_TICKS<<plane clocks (binary-coded modulation).
// Optional macro SCAN_FRAME_PULSE_EN adds out_FRAME, a one-clock pulse at the end of each frame.
module hub75_scan_ctrl #(
    parameter int COLS       = 64,
    parameter int ROW_BITS   = 5,
    parameter int PLANES     = 8,
    parameter int BASE_TICKS = 4
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        in_EN,
    input  logic                                        in_VALID,
    input  logic [5:0]                                  in_RGB01,
    output logic                                        out_REQ,
    output logic [ROW_BITS-1:0]                         out_REQ_ROW,
    output logic                                        out_REQ_HALF,
    output logic [((PLANES > 1) ? $clog2(PLANES) : 1)-1:0] out_REQ_PLANE,
    output logic                                        out_LOAD0,
    output logic                                        out_LOAD1,
    output logic                                        out_SHIFT,
    output logic                                        out_PCLK,
    output logic [5:0]                                  out_RGB,
    output logic                                        out_LAT,
    output logic                                        out_OE_n,
`ifdef SCAN_FRAME_PULSE_EN
    output logic                                        out_FRAME,
`endif
    output logic [ROW_BITS-1:0]                         out_ROW
);

    localparam int PLANE_W = (PLANES > 1) ? $clog2(PLANES) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int TIMER_W = $clog2(BASE_TICKS) + PLANES;

    localparam logic [PLANE_W-1:0]  LAST_PLANE = PLANE_W'(PLANES - 1);
    localparam logic [COL_W-1:0]    LAST_COL   = COL_W'(COLS - 1);
    localparam logic [ROW_BITS-1:0] LAST_ROW   = {ROW_BITS{1'b1}};
    localparam logic [TIMER_W-1:0]  BASE_T     = TIMER_W'(BASE_TICKS);

    typedef enum logic [2:0] {
        IDLE,
        FETCH0,
        FETCH1,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    state_t               state_reg, state_next;
    logic [ROW_BITS-1:0]  row_reg, row_next;
    logic [PLANE_W-1:0]   plane_reg, plane_next;
    logic [COL_W-1:0]     col_reg, col_next;
    logic                 phase_reg, phase_next;
    logic [TIMER_W-1:0]   timer_reg, timer_next;
    logic [5:0]           rgb_reg;
    logic [ROW_BITS-1:0]  out_row_reg;
    logic                 display_expiry;
    logic                 rgb_capture;
    logic                 row_capture;

    // Timer counts down to zero; the cycle it reads zero is the last lit clock of the plane.
    assign display_expiry = (state_reg == DISPLAY) && (timer_reg == '0);
    assign rgb_capture    = (state_reg == SHIFT) && !phase_reg;
    assign row_capture    = (state_reg == LATCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            row_reg   <= '0;
            plane_reg <= '0;
            col_reg   <= '0;
            phase_reg <= 1'b0;
            timer_reg <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
            plane_reg <= plane_next;
            col_reg   <= col_next;
            phase_reg <= phase_next;
            timer_reg <= timer_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_reg     <= '0;
            out_row_reg <= '0;
        end else begin
            if (rgb_capture) begin
                rgb_reg <= in_RGB01;
            end
            if (row_capture) begin
                out_row_reg <= row_reg;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        plane_next = plane_reg;
        col_next   = col_reg;
        phase_next = phase_reg;
        timer_next = timer_reg;

        case (state_reg)
            IDLE: begin
                row_next   = '0;
                plane_next = '0;
                col_next   = '0;
                phase_next = 1'b0;
                if (in_EN) begin
                    state_next = FETCH0;
                end
            end
            FETCH0: begin
                if (in_VALID) begin
                    state_next = FETCH1;
                end
            end
            FETCH1: begin
                col_next   = '0;
                phase_next = 1'b0;
                if (in_VALID) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                phase_next = !phase_reg;
                if (phase_reg) begin
                    if (col_reg == LAST_COL) begin
                        col_next   = '0;
                        state_next = LATCH;
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            LATCH: begin
                timer_next = (BASE_T << plane_reg) - 1'b1;
                state_next = DISPLAY;
            end
            DISPLAY: begin
                if (timer_reg == '0) begin
                    if (plane_reg == LAST_PLANE) begin
                        plane_next = '0;
                        row_next   = row_reg + 1'b1;
                    end else begin
                        plane_next = plane_reg + 1'b1;
                    end
                    if (in_EN) begin
                        state_next = FETCH0;
                    end else begin
                        // A stopped scan restarts from the top of the frame.
                        state_next = IDLE;
                        row_next   = '0;
                        plane_next = '0;
                    end
                end else begin
                    timer_next = timer_reg - 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs decode directly from the state register so an async reset blanks the panel at once.
    always_comb begin
        out_REQ      = (state_reg == FETCH0) || (state_reg == FETCH1);
        out_REQ_HALF = (state_reg == FETCH1);
        out_LOAD0    = (state_reg == FETCH0) && in_VALID;
        out_LOAD1    = (state_reg == FETCH1) && in_VALID;
        out_SHIFT    = (state_reg == SHIFT) && phase_reg;
        out_PCLK     = (state_reg == SHIFT) && phase_reg;
        out_LAT      = (state_reg == LATCH);
        out_OE_n     = (state_reg != DISPLAY);
    end

    assign out_REQ_ROW   = row_reg;
    assign out_REQ_PLANE = plane_reg;
    assign out_RGB       = rgb_reg;
    assign out_ROW       = out_row_reg;

`ifdef SCAN_FRAME_PULSE_EN
    assign out_FRAME = display_expiry && (plane_reg == LAST_PLANE) && (row_reg == LAST_ROW);
`endif

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Self-checking bench for hub75_scan_ctrl: randomized memory latency and pixel data, checked
// against an expected (row, plane) scan order and per-plane timing derived from the BCM rules.
module tb_hub75_scan_ctrl;

    localparam int COLS       = 64;
    localparam int ROW_BITS   = 5;
    localparam int PLANES     = 8;
    localparam int BASE_TICKS = 4;
    localparam int ROWS       = 1 << ROW_BITS;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_EN = 1'b0;
    logic                in_VALID = 1'b0;
    logic [5:0]          in_RGB01 = '0;
    logic                out_REQ;
    logic [ROW_BITS-1:0] out_REQ_ROW;
    logic                out_REQ_HALF;
    logic [2:0]          out_REQ_PLANE;
    logic                out_LOAD0;
    logic                out_LOAD1;
    logic                out_SHIFT;
    logic                out_PCLK;
    logic [5:0]          out_RGB;
    logic                out_LAT;
    logic                out_OE_n;
    logic [ROW_BITS-1:0] out_ROW;
    logic                frame_sig;

    int checks = 0;
    int errors = 0;
    int frame_pulses = 0;

    hub75_scan_ctrl #(
        .COLS(COLS), .ROW_BITS(ROW_BITS), .PLANES(PLANES), .BASE_TICKS(BASE_TICKS)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_EN(in_EN),
        .in_VALID(in_VALID),
        .in_RGB01(in_RGB01),
        .out_REQ(out_REQ),
        .out_REQ_ROW(out_REQ_ROW),
        .out_REQ_HALF(out_REQ_HALF),
        .out_REQ_PLANE(out_REQ_PLANE),
        .out_LOAD0(out_LOAD0),
        .out_LOAD1(out_LOAD1),
        .out_SHIFT(out_SHIFT),
        .out_PCLK(out_PCLK),
        .out_RGB(out_RGB),
        .out_LAT(out_LAT),
        .out_OE_n(out_OE_n),
`ifdef SCAN_FRAME_PULSE_EN
        .out_FRAME(frame_sig),
`endif
        .out_ROW(out_ROW)
    );

`ifndef SCAN_FRAME_PULSE_EN
    assign frame_sig = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One plane of one row: two fetches, COLS shifts, a latch, then the lit period.
    task automatic run_plane(input int er, input int ep, input int lat, input bit drop_en,
                             input bit rst_mid);
        int k;
        int bad;
        int pulses;
        int width;
        logic [5:0] rgb_prev;
        rgb_prev = '0;
        for (int h = 0; h < 2; h++) begin
            k = 0;
            while (out_REQ !== 1'b1 && k < 200) begin
                @(negedge clk);
                k++;
            end
            chk("req_seen", 32'(out_REQ), 32'd1);
            chk("req_row", 32'(out_REQ_ROW), 32'(er));
            chk("req_plane", 32'(out_REQ_PLANE), 32'(ep));
            chk("req_half", 32'(out_REQ_HALF), 32'(h));
            bad = 0;
            repeat (lat) begin
                @(negedge clk);
                if (out_LOAD0 !== 1'b0 || out_LOAD1 !== 1'b0 || out_REQ !== 1'b1) bad++;
            end
            chk("fetch_wait", 32'(bad), 32'd0);
            in_VALID = 1'b1;
            #1;
            chk("load0", 32'(out_LOAD0), 32'(h == 0));
            chk("load1", 32'(out_LOAD1), 32'(h == 1));
            @(negedge clk);
            in_VALID = 1'b0;
        end
        pulses = 0;
        bad = 0;
        for (int c = 0; c < 2 * COLS; c++) begin
            if (out_PCLK !== 1'(c % 2) || out_SHIFT !== out_PCLK || out_OE_n !== 1'b1 ||
                out_LAT !== 1'b0 || out_REQ !== 1'b0) bad++;
            if (c % 2 == 0) begin
                rgb_prev = 6'($urandom);
                in_RGB01 = rgb_prev;
            end else if (out_RGB !== rgb_prev) begin
                bad++;
            end
            if (out_SHIFT === 1'b1) pulses++;
            if (drop_en && c == COLS) in_EN = 1'b0;
            @(negedge clk);
        end
        chk("shift_seq", 32'(bad), 32'd0);
        chk("shift_pulses", 32'(pulses), 32'(COLS));
        chk("lat", 32'(out_LAT), 32'd1);
        chk("lat_oe_n", 32'(out_OE_n), 32'd1);
        chk("lat_pclk", 32'(out_PCLK), 32'd0);
        @(negedge clk);
        chk("out_row", 32'(out_ROW), 32'(er));
        width = 0;
        while (out_OE_n === 1'b0 && width < 5000) begin
            width++;
            if (frame_sig === 1'b1) frame_pulses++;
            if (rst_mid && width == 3) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rst_oe_n", 32'(out_OE_n), 32'd1);
                chk("rst_req", 32'(out_REQ), 32'd0);
                chk("rst_row", 32'(out_ROW), 32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        chk("oe_width", 32'(width), 32'(BASE_TICKS << ep));
    endtask

    initial begin
        int bad;
        // Reset state, checked while held and after release.
        repeat (3) @(negedge clk);
        chk("rst_held_oe_n", 32'(out_OE_n), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_oe_n", 32'(out_OE_n), 32'd1);
        chk("rst_req", 32'(out_REQ), 32'd0);
        chk("rst_lat", 32'(out_LAT), 32'd0);
        chk("rst_pclk", 32'(out_PCLK), 32'd0);
        chk("rst_shift", 32'(out_SHIFT), 32'd0);
        chk("rst_rgb", 32'(out_RGB), 32'd0);
        chk("rst_row", 32'(out_ROW), 32'd0);
        chk("rst_frame", 32'(frame_sig), 32'd0);

        // Disabled: stray VALID is ignored, no requests, panel dark.
        bad = 0;
        repeat (100) begin
            in_VALID = 1'($urandom);
            #1;
            if (out_REQ !== 1'b0 || out_OE_n !== 1'b1 || out_LOAD0 !== 1'b0 ||
                out_LOAD1 !== 1'b0) bad++;
            @(negedge clk);
        end
        in_VALID = 1'b0;
        chk("idle_quiet", 32'(bad), 32'd0);

        // Full frame in scan order: plane fastest, then row.
        in_EN = 1'b1;
        for (int idx = 0; idx < ROWS * PLANES; idx++) begin
            if (idx == ROWS * PLANES - 1) chk("frame_early", 32'(frame_pulses), 32'd0);
            run_plane((idx / PLANES) % ROWS, idx % PLANES,
                      (idx == 0) ? 3 : int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end
`ifdef SCAN_FRAME_PULSE_EN
        chk("frame_pulse", 32'(frame_pulses), 32'd1);
`else
        chk("frame_absent", 32'(frame_pulses), 32'd0);
`endif

        // Row wrapped to 0; drop enable mid-shift of plane 2 and expect a clean stop.
        run_plane(0, 0, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        run_plane(0, 1, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        run_plane(0, 2, int'($urandom_range(0, 3)), 1'b1, 1'b0);
        bad = 0;
        repeat (20) begin
            if (out_REQ !== 1'b0 || out_OE_n !== 1'b1) bad++;
            @(negedge clk);
        end
        chk("stopped_idle", 32'(bad), 32'd0);

        // Re-enable restarts at row 0 plane 0; then async reset while lit.
        in_EN = 1'b1;
        run_plane(0, 0, int'($urandom_range(0, 3)), 1'b0, 1'b0);
        run_plane(0, 1, int'($urandom_range(0, 3)), 1'b0, 1'b1);
        run_plane(0, 0, int'($urandom_range(0, 3)), 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
